shift_sequencer: RTL and testbench

Multi-cycle controller that sequences the combinational barrel_shifter for the execute stage's data-processing operand 2. It accepts one operand-2 request per handshake, decodes the 12-bit operand-2 field (rotated immediate, immediate-shift, register-shift), and fetches Rs through the shared register-file read port when needed. It maps out-of-range register shift amounts onto the shifter's 5-bit encoding, then presents a registered {Op2, Carry} result on a valid/ready interface.

---
 rtl/shift_sequencer_pkg.sv | 52 +++++
 rtl/shift_sequencer_barrel.sv | 80 ++++++++
 rtl/shift_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_shift_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// rtl/shift_sequencer_pkg.sv - shared types, field positions and helpers for shift_sequencer
//
// Purpose: state encoding, operand-2 field bit positions, shift-type codes and
// the amount-fixup result type used by shift_sequencer and its barrel shifter.
package shift_sequencer_pkg;

  localparam int WORD_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 4;

  // Shift-type codes as they appear in operand-2 bits [6:5]
  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // Operand-2 field positions
  localparam int OP2_ROT_LSB       = 8;  // rotate (immediate form) and Rs index
  localparam int OP2_IMM_LSB       = 0;  // 8-bit immediate
  localparam int OP2_SHAMT_LSB     = 7;  // 5-bit immediate shift amount
  localparam int OP2_TYPE_LSB      = 5;  // 2-bit shift type
  localparam int OP2_REG_SHIFT_BIT = 4;  // 1 = shift amount comes from Rs

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RS_REQ,
    ST_RS_DATA,
    ST_EXEC,
    ST_RESULT
  } state_e;

  // Register amounts the shifter cannot encode are resolved by overriding its result
  typedef enum logic [1:0] {
    OVR_NONE,
    OVR_ZERO,
    OVR_RM
  } ovr_e;

  typedef struct packed {
    logic [1:0] sh_type;
    logic [4:0] sh_amt;
    ovr_e       ovr;
    logic       ovr_carry;
  } fixup_t;

  function automatic logic [WORD_WIDTH-1:0] ror_word(input logic [WORD_WIDTH-1:0] v,
                                                     input logic [4:0]            n);
    logic [2*WORD_WIDTH-1:0] t;
    t = {v, v} >> n;
    return t[WORD_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/shift_sequencer_barrel.sv
// rtl/shift_sequencer_barrel.sv - combinational operand-2 barrel shifter
//
// Purpose: rotated-immediate and 5-bit-amount shifts with the native #0
// encodings (LSR#32, ASR#32, RRX).
// Ports:
//   imm_form_i    1 = rotated 8-bit immediate
//   rotate_i      immediate rotate field (rotation = 2 * rotate_i)
//   imm_i         8-bit immediate
//   shift_type_i  LSL/LSR/ASR/ROR
//   amount_i      5-bit shift amount
//   rm_i, c_i     operand value and incoming carry
//   op2_o, carry_o shifted operand and carry-out
module shift_sequencer_barrel
  import shift_sequencer_pkg::*;
(
  input  logic                  imm_form_i,
  input  logic [3:0]            rotate_i,
  input  logic [7:0]            imm_i,
  input  logic [1:0]            shift_type_i,
  input  logic [4:0]            amount_i,
  input  logic [WORD_WIDTH-1:0] rm_i,
  input  logic                  c_i,
  output logic [WORD_WIDTH-1:0] op2_o,
  output logic                  carry_o
);

  logic [4:0] amt_m1;
  logic [4:0] amt_neg;

  // Last bit shifted out: Rm[amt-1] for right shifts, Rm[32-amt] for LSL
  assign amt_m1  = amount_i - 5'd1;
  assign amt_neg = 5'd0 - amount_i;

  always_comb begin
    op2_o   = rm_i;
    carry_o = c_i;
    if (imm_form_i) begin
      op2_o = ror_word({{(WORD_WIDTH-8){1'b0}}, imm_i}, {rotate_i, 1'b0});
      if (rotate_i != 4'd0) carry_o = op2_o[WORD_WIDTH-1];
    end else begin
      case (shift_type_i)
        SH_LSL: begin
          if (amount_i != 5'd0) begin
            op2_o   = rm_i << amount_i;
            carry_o = rm_i[amt_neg];
          end
        end
        SH_LSR: begin
          if (amount_i == 5'd0) begin
            op2_o   = '0;
            carry_o = rm_i[WORD_WIDTH-1];
          end else begin
            op2_o   = rm_i >> amount_i;
            carry_o = rm_i[amt_m1];
          end
        end
        SH_ASR: begin
          if (amount_i == 5'd0) begin
            op2_o   = {WORD_WIDTH{rm_i[WORD_WIDTH-1]}};
            carry_o = rm_i[WORD_WIDTH-1];
          end else begin
            op2_o   = $signed(rm_i) >>> amount_i;
            carry_o = rm_i[amt_m1];
          end
        end
        default: begin
          if (amount_i == 5'd0) begin
            // RRX
            op2_o   = {c_i, rm_i[WORD_WIDTH-1:1]};
            carry_o = rm_i[0];
          end else begin
            op2_o   = ror_word(rm_i, amount_i);
            carry_o = rm_i[amt_m1];
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle operand-2 shift sequencer
//
// Purpose: accepts one operand-2 request, fetches Rs over the shared register
// port when the shift amount is register-sourced, runs the barrel shifter and
// holds a registered {Op2, Carry} result until the consumer takes it.
// Ports:
//   in_Clk, in_Rst            clock, asynchronous active-high reset
//   in_Valid / out_Ready      request handshake (ready only in IDLE)
//   in_ImmForm, in_Operand2   I bit and instruction bits [11:0]
//   in_Rm_val, in_C_flag      Rm value and CPSR C, sampled at accept
//   out_RsRead, out_RsAddr    register-file read request and Rs index
//   in_RsGrant, in_RsData     grant; data arrives the cycle after grant
//   in_Flush                  synchronous abort to IDLE
//   out_Valid / in_Ready      result handshake
//   out_Op2, out_Carry        registered result
module shift_sequencer
  import shift_sequencer_pkg::*;
(
  input  logic                      in_Clk,
  input  logic                      in_Rst,
  input  logic                      in_Valid,
  output logic                      out_Ready,
  input  logic                      in_ImmForm,
  input  logic [11:0]               in_Operand2,
  input  logic [WORD_WIDTH-1:0]     in_Rm_val,
  input  logic                      in_C_flag,
  output logic                      out_RsRead,
  output logic [REG_ADDR_WIDTH-1:0] out_RsAddr,
  input  logic                      in_RsGrant,
  input  logic [WORD_WIDTH-1:0]     in_RsData,
  input  logic                      in_Flush,
  output logic                      out_Valid,
  input  logic                      in_Ready,
  output logic [WORD_WIDTH-1:0]     out_Op2,
  output logic                      out_Carry
);

  state_e                state_q, state_d;
  logic                  imm_form_q, imm_form_d;
  logic [11:0]           field_q, field_d;
  logic [WORD_WIDTH-1:0] rm_q, rm_d;
  logic                  c_q, c_d;
  logic [7:0]            rs_amt_q, rs_amt_d;
  logic [WORD_WIDTH-1:0] op2_q, op2_d;
  logic                  carry_q, carry_d;

  logic                  reg_shift;
  fixup_t                fix;
  logic [1:0]            sh_type;
  logic [4:0]            sh_amt;
  logic [WORD_WIDTH-1:0] sh_op2;
  logic                  sh_carry;
  logic                  unused_rsdata;

  // Only the low byte of Rs is a shift amount
  assign unused_rsdata = ^in_RsData[WORD_WIDTH-1:8];

  // Maps an 8-bit register amount onto the shifter's 5-bit encoding, or
  // flags an override when no encoding produces the required result.
  function automatic fixup_t fix_reg_amount(input logic [1:0]            typ,
                                            input logic [7:0]            amt,
                                            input logic [WORD_WIDTH-1:0] rm);
    fixup_t f;
    f.sh_type   = typ;
    f.sh_amt    = amt[4:0];
    f.ovr       = OVR_NONE;
    f.ovr_carry = 1'b0;
    if (amt == 8'd0) begin
      // LSL #0 passes Rm and C through for every type
      f.sh_type = SH_LSL;
      f.sh_amt  = 5'd0;
    end else begin
      case (typ)
        SH_LSL: begin
          if (amt == 8'd32) begin
            f.ovr       = OVR_ZERO;
            f.ovr_carry = rm[0];
          end else if (amt > 8'd32) begin
            f.ovr = OVR_ZERO;
          end
        end
        SH_LSR: begin
          if (amt == 8'd32)     f.sh_amt = 5'd0;
          else if (amt > 8'd32) f.ovr    = OVR_ZERO;
        end
        SH_ASR: begin
          if (amt >= 8'd32) f.sh_amt = 5'd0;
        end
        default: begin
          // Multiples of 32 must not fall into RRX
          if (amt[4:0] == 5'd0) begin
            f.ovr       = OVR_RM;
            f.ovr_carry = rm[WORD_WIDTH-1];
          end
        end
      endcase
    end
    return f;
  endfunction

  assign reg_shift = !imm_form_q && field_q[OP2_REG_SHIFT_BIT];
  assign fix       = fix_reg_amount(field_q[OP2_TYPE_LSB +: 2], rs_amt_q, rm_q);
  assign sh_type   = reg_shift ? fix.sh_type : field_q[OP2_TYPE_LSB +: 2];
  assign sh_amt    = reg_shift ? fix.sh_amt  : field_q[OP2_SHAMT_LSB +: 5];

  shift_sequencer_barrel u_barrel (
    .imm_form_i   (imm_form_q),
    .rotate_i     (field_q[OP2_ROT_LSB +: 4]),
    .imm_i        (field_q[OP2_IMM_LSB +: 8]),
    .shift_type_i (sh_type),
    .amount_i     (sh_amt),
    .rm_i         (rm_q),
    .c_i          (c_q),
    .op2_o        (sh_op2),
    .carry_o      (sh_carry)
  );

  always_ff @(posedge in_Clk or posedge in_Rst) begin
    if (in_Rst) begin
      state_q    <= ST_IDLE;
      imm_form_q <= 1'b0;
      field_q    <= '0;
      rm_q       <= '0;
      c_q        <= 1'b0;
      rs_amt_q   <= '0;
      op2_q      <= '0;
      carry_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      imm_form_q <= imm_form_d;
      field_q    <= field_d;
      rm_q       <= rm_d;
      c_q        <= c_d;
      rs_amt_q   <= rs_amt_d;
      op2_q      <= op2_d;
      carry_q    <= carry_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    imm_form_d = imm_form_q;
    field_d    = field_q;
    rm_d       = rm_q;
    c_d        = c_q;
    rs_amt_d   = rs_amt_q;
    op2_d      = op2_q;
    carry_d    = carry_q;
    case (state_q)
      ST_IDLE: begin
        if (in_Valid && !in_Flush) begin
          imm_form_d = in_ImmForm;
          field_d    = in_Operand2;
          rm_d       = in_Rm_val;
          c_d        = in_C_flag;
          state_d    = (in_ImmForm || !in_Operand2[OP2_REG_SHIFT_BIT]) ? ST_EXEC : ST_RS_REQ;
        end
      end
      ST_RS_REQ:  if (in_RsGrant) state_d = ST_RS_DATA;
      ST_RS_DATA: begin
        rs_amt_d = in_RsData[7:0];
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        op2_d   = sh_op2;
        carry_d = sh_carry;
        if (reg_shift && fix.ovr != OVR_NONE) begin
          op2_d   = (fix.ovr == OVR_ZERO) ? '0 : rm_q;
          carry_d = fix.ovr_carry;
        end
        state_d = ST_RESULT;
      end
      ST_RESULT:  if (in_Ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (in_Flush) state_d = ST_IDLE;
  end

  assign out_Ready  = (state_q == ST_IDLE);
  assign out_RsRead = (state_q == ST_RS_REQ);
  assign out_Valid  = (state_q == ST_RESULT);
  assign out_RsAddr = field_q[OP2_ROT_LSB +: REG_ADDR_WIDTH];
  assign out_Op2    = op2_q;
  assign out_Carry  = carry_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - self-checking bench for shift_sequencer
module tb_shift_sequencer;

  logic        in_Clk = 1'b0;
  logic        in_Rst;
  logic        in_Valid;
  logic        out_Ready;
  logic        in_ImmForm;
  logic [11:0] in_Operand2;
  logic [31:0] in_Rm_val;
  logic        in_C_flag;
  logic        out_RsRead;
  logic [3:0]  out_RsAddr;
  logic        in_RsGrant;
  logic [31:0] in_RsData;
  logic        in_Flush;
  logic        out_Valid;
  logic        in_Ready;
  logic [31:0] out_Op2;
  logic        out_Carry;

  int n_vec = 0;
  int n_err = 0;

  shift_sequencer dut (
    .in_Clk      (in_Clk),
    .in_Rst      (in_Rst),
    .in_Valid    (in_Valid),
    .out_Ready   (out_Ready),
    .in_ImmForm  (in_ImmForm),
    .in_Operand2 (in_Operand2),
    .in_Rm_val   (in_Rm_val),
    .in_C_flag   (in_C_flag),
    .out_RsRead  (out_RsRead),
    .out_RsAddr  (out_RsAddr),
    .in_RsGrant  (in_RsGrant),
    .in_RsData   (in_RsData),
    .in_Flush    (in_Flush),
    .out_Valid   (out_Valid),
    .in_Ready    (in_Ready),
    .out_Op2     (out_Op2),
    .out_Carry   (out_Carry)
  );

  always #5 in_Clk = ~in_Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] v, input int n);
    if (n == 0) return v;
    return (v >> n) | (v << (32 - n));
  endfunction

  // Reference result {carry, op2} from the architectural shift rules
  function automatic logic [32:0] model(input logic imm, input logic [11:0] f,
                                        input logic [31:0] m, input logic c,
                                        input logic [31:0] rs);
    int          a;
    logic [1:0]  t;
    logic [63:0] w;
    logic [31:0] r;
    if (imm) begin
      r = rotr(32'(f[7:0]), 2 * int'(f[11:8]));
      return {(f[11:8] == 4'd0) ? c : r[31], r};
    end
    t = f[6:5];
    if (!f[4]) begin
      a = int'(f[11:7]);
      if (a == 0) begin
        if (t == 2'b00) return {c, m};
        if (t == 2'b11) return {m[0], c, m[31:1]};
        a = 32;
      end
    end else begin
      a = int'(rs[7:0]);
      if (a == 0) return {c, m};
    end
    case (t)
      2'b00: begin
        if (a > 32) return 33'd0;
        w = {32'd0, m} << a;
        return {w[32], w[31:0]};
      end
      2'b01: begin
        if (a > 32) return 33'd0;
        w = {m, 32'd0} >> a;
        return {w[31], w[63:32]};
      end
      2'b10: begin
        if (a > 32) a = 32;
        w = $signed({m, 32'd0}) >>> a;
        return {w[31], w[63:32]};
      end
      default: begin
        r = rotr(m, a % 32);
        return {r[31], r};
      end
    endcase
  endfunction

  task automatic accept(input logic imm, input logic [11:0] f, input logic [31:0] m, input logic c);
    chk("accept_ready", out_Ready, 1);
    in_ImmForm  = imm;
    in_Operand2 = f;
    in_Rm_val   = m;
    in_C_flag   = c;
    in_Valid    = 1'b1;
  endtask

  task automatic scramble();
    in_ImmForm  = 1'($urandom);
    in_Operand2 = 12'($urandom);
    in_Rm_val   = $urandom;
    in_C_flag   = 1'($urandom);
    in_RsData   = $urandom;
  endtask

  // Called and returns at a negedge; gd = cycles without grant, rd = cycles of in_Ready low
  task automatic run_req(input logic imm, input logic [11:0] f, input logic [31:0] m,
                         input logic c, input logic [31:0] rs, input int gd, input int rd,
                         input string tag, output logic [31:0] o_op2, output logic o_c);
    logic [32:0] e;
    logic        need_rs;
    int          cyc;
    e       = model(imm, f, m, c, rs);
    need_rs = !imm && f[4];
    accept(imm, f, m, c);
    cyc = 0;
    while (cyc < 40) begin
      @(negedge in_Clk);
      cyc++;
      in_Valid   = 1'b0;
      in_RsGrant = 1'b0;
      scramble();
      if (out_Valid) break;
      chk({tag, "_rsread"}, out_RsRead, need_rs && (cyc <= 1 + gd));
      if (out_RsRead) chk({tag, "_rsaddr"}, out_RsAddr, f[11:8]);
      if (need_rs && cyc == 1 + gd) in_RsGrant = 1'b1;
      if (need_rs && cyc == 2 + gd) in_RsData = rs;
    end
    chk({tag, "_latency"}, cyc, need_rs ? 4 + gd : 2);
    o_op2 = out_Op2;
    o_c   = out_Carry;
    chk({tag, "_op2"}, out_Op2, e[31:0]);
    chk({tag, "_carry"}, out_Carry, e[32]);
    for (int i = 0; i < rd; i++) begin
      @(negedge in_Clk);
      scramble();
      chk({tag, "_hold_valid"}, out_Valid, 1);
      chk({tag, "_hold_op2"}, out_Op2, e[31:0]);
      chk({tag, "_hold_carry"}, out_Carry, e[32]);
    end
    in_Ready = 1'b1;
    @(negedge in_Clk);
    in_Ready = 1'b0;
    chk({tag, "_done_valid"}, out_Valid, 0);
    chk({tag, "_done_ready"}, out_Ready, 1);
  endtask

  initial begin
    logic [31:0] o;
    logic        oc;
    logic        imm;
    logic [11:0] f;
    logic [31:0] rs;
    int          k;

    in_Rst = 1'b1; in_Valid = 1'b0; in_ImmForm = 1'b0; in_Operand2 = '0;
    in_Rm_val = '0; in_C_flag = 1'b0; in_RsGrant = 1'b0; in_RsData = '0;
    in_Flush = 1'b0; in_Ready = 1'b0;
    repeat (2) @(negedge in_Clk);
    chk("rst_ready", out_Ready, 1);
    chk("rst_valid", out_Valid, 0);
    chk("rst_rsread", out_RsRead, 0);
    chk("rst_rsaddr", out_RsAddr, 0);
    chk("rst_op2", out_Op2, 0);
    chk("rst_carry", out_Carry, 0);
    in_Rst = 1'b0;

    run_req(1'b1, 12'h1C8, 32'hDEAD_BEEF, 1'b1, 32'd0, 0, 0, "imm_rot", o, oc);
    chk("imm_rot_k_op2", o, 32'd50);
    chk("imm_rot_k_carry", oc, 0);
    run_req(1'b0, 12'h312, 32'd1, 1'b0, 32'd32, 0, 0, "lsl32", o, oc);
    chk("lsl32_k_op2", o, 0);
    chk("lsl32_k_carry", oc, 1);
    run_req(1'b0, 12'h312, 32'd1, 1'b1, 32'd40, 0, 0, "lsl40", o, oc);
    chk("lsl40_k_op2", o, 0);
    chk("lsl40_k_carry", oc, 0);
    run_req(1'b0, 12'h332, 32'h8000_0000, 1'b0, 32'd32, 0, 0, "lsr32", o, oc);
    chk("lsr32_k_op2", o, 0);
    chk("lsr32_k_carry", oc, 1);
    run_req(1'b0, 12'h352, 32'h8000_0000, 1'b0, 32'd200, 0, 0, "asr200", o, oc);
    chk("asr200_k_op2", o, 32'hFFFF_FFFF);
    chk("asr200_k_carry", oc, 1);
    run_req(1'b0, 12'h372, 32'd200, 1'b1, 32'd64, 0, 0, "ror64", o, oc);
    chk("ror64_k_op2", o, 32'd200);
    chk("ror64_k_carry", oc, 0);
    run_req(1'b0, 12'h372, 32'd200, 1'b1, 32'h100, 0, 0, "ror256", o, oc);
    chk("ror256_k_op2", o, 32'd200);
    chk("ror256_k_carry", oc, 1);

    // Asynchronous reset while in RS_DATA
    accept(1'b0, 12'h712, 32'h1234, 1'b0);
    @(negedge in_Clk);
    in_Valid = 1'b0;
    in_RsGrant = 1'b1;
    chk("rstmid_rsread_req", out_RsRead, 1);
    @(negedge in_Clk);
    in_RsGrant = 1'b0;
    chk("rstmid_rsread_data", out_RsRead, 0);
    #1 in_Rst = 1'b1;
    #1;
    chk("rstmid_ready", out_Ready, 1);
    chk("rstmid_valid", out_Valid, 0);
    chk("rstmid_rsread", out_RsRead, 0);
    chk("rstmid_rsaddr", out_RsAddr, 0);
    chk("rstmid_op2", out_Op2, 0);
    chk("rstmid_carry", out_Carry, 0);
    @(negedge in_Clk);
    in_Rst = 1'b0;
    chk("rstmid_ready_after", out_Ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge in_Clk);
      chk("rstmid_lost_valid", out_Valid, 0);
      chk("rstmid_lost_rsread", out_RsRead, 0);
    end

    run_req(1'b0, 12'h952, 32'h8765_4321, 1'b0, 32'd4, 3, 2, "grant_wait", o, oc);

    // Flush while holding a result
    accept(1'b1, 12'h0FF, 32'd0, 1'b0);
    k = 0;
    do begin
      @(negedge in_Clk);
      in_Valid = 1'b0;
      k++;
    end while (!out_Valid && k < 10);
    chk("flush_res_valid_before", out_Valid, 1);
    in_Flush = 1'b1;
    @(negedge in_Clk);
    in_Flush = 1'b0;
    chk("flush_res_valid", out_Valid, 0);
    chk("flush_res_ready", out_Ready, 1);

    // Flush while requesting Rs, with a grant in the same cycle
    accept(1'b0, 12'h312, 32'd5, 1'b0);
    @(negedge in_Clk);
    in_Valid = 1'b0;
    chk("flush_req_rsread_before", out_RsRead, 1);
    in_Flush = 1'b1;
    in_RsGrant = 1'b1;
    @(negedge in_Clk);
    in_Flush = 1'b0;
    in_RsGrant = 1'b0;
    chk("flush_req_rsread", out_RsRead, 0);
    chk("flush_req_ready", out_Ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge in_Clk);
      chk("flush_req_no_valid", out_Valid, 0);
    end

    for (int n = 0; n < 60; n++) begin
      imm = 1'($urandom);
      f   = 12'($urandom);
      if (!imm && $urandom_range(2, 0) != 0) begin
        f[4] = 1'b1;
        f[7] = 1'b0;
      end
      case ($urandom_range(4, 0))
        0:       rs = $urandom & 32'hFFFF_FF00;
        1:       rs = $urandom_range(31, 1);
        2:       rs = 32'd32;
        3:       rs = $urandom_range(255, 33);
        default: rs = $urandom & 32'hFFFF_FFE0;
      endcase
      run_req(imm, f, $urandom, 1'($urandom), rs, $urandom_range(3, 0),
              $urandom_range(2, 0), "rand", o, oc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
